oled_spi_streamer: RTL and testbench

- Parametrised OLED serial transmitter, the next generation of the chip-level OLED pin driver; sits between game/render logic and the oled_* pads.
- Runs the panel power-up reset sequence, then serialises command bytes or pixel words (SPI mode 3, MSB first) from a valid/ready stream.
- Drives the panel's D/C and chip-select per word. Holds CS low across back-to-back words.

---
 rtl/oled_pkg.sv | 15 +
 rtl/oled_sclk_tick.sv | 42 ++++
 rtl/oled_spi_streamer.sv | 165 ++++++++++++++++
 tb/tb_oled_spi_streamer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED serial streamer.
package oled_pkg;

  typedef enum logic [2:0] {RES_LOW, RES_WAIT, IDLE, SHIFT, GAP} oled_state_t;

  localparam logic SCLK_IDLE = 1'b1;
  localparam int   CMD_W     = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/oled_sclk_tick.sv
// Half-period timer for the serial clock: marks the falling and rising edge
// of each bit and the last cycle of each bit period while shifting.
module oled_sclk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic fall_tick,
  output logic rise_tick,
  output logic bit_end
);

  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          high_half;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= HALF_LAST;
      high_half <= 1'b0;
    end else if (clr) begin
      cnt       <= HALF_LAST;
      high_half <= 1'b0;
    end else if (en) begin
      if (cnt == '0) begin
        cnt       <= HALF_LAST;
        high_half <= ~high_half;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign fall_tick = en && !high_half && (cnt == HALF_LAST);
  assign rise_tick = en &&  high_half && (cnt == HALF_LAST);
  assign bit_end   = en &&  high_half && (cnt == '0);

endmodule

// File: rtl/oled_spi_streamer.sv
// OLED panel transmitter: runs the panel reset sequence, then shifts words out
// in SPI mode 3, MSB first, holding chip select across back-to-back words.
//
// state    | meaning
// RES_LOW  | panel reset asserted
// RES_WAIT | panel reset released, waiting for the panel to come up
// IDLE     | ready, chip select high
// SHIFT    | serialising the latched word
// GAP      | word done, chip select held low briefly for a follow-on word
module oled_spi_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV         = 2,
  parameter int DATA_W          = 16,
  parameter int RES_LOW_CYCLES  = 250,
  parameter int RES_WAIT_CYCLES = 2500,
  parameter int CS_IDLE_CYCLES  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dc,
  input  logic              in_len8,
  input  logic              hw_reset_req,
  output logic              init_done,
  output logic              busy,
  output logic              oled_clk,
  output logic              oled_mosi,
  output logic              oled_dc,
  output logic              oled_res_n,
  output logic              oled_cs_n
);

  localparam int CNT_MAX = max3(RES_LOW_CYCLES, RES_WAIT_CYCLES, CS_IDLE_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(DATA_W);

  localparam logic [CW-1:0] RES_LOW_LAST  = CW'(RES_LOW_CYCLES - 1);
  localparam logic [CW-1:0] RES_WAIT_LAST = CW'(RES_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST      = CW'(CS_IDLE_CYCLES - 1);

  oled_state_t       state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [DATA_W-1:0] shreg, load_word;
  logic [BW-1:0]     bits_left;
  logic              open_state, accept, reset_take, last_bit;
  logic              fall_tick, rise_tick, bit_end;

  assign open_state = (state == IDLE) || (state == GAP);
  assign in_ready   = open_state && !hw_reset_req;
  assign accept     = in_valid && in_ready;
  assign reset_take = open_state && hw_reset_req;
  assign last_bit   = bit_end && (bits_left == '0);
  // An 8-bit command is moved to the top so the MSB-first shifter needs no special case.
  assign load_word  = in_len8 ? (DATA_W'(in_data[CMD_W-1:0]) << (DATA_W - CMD_W)) : in_data;

  oled_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (accept),
    .en        (state == SHIFT),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick),
    .bit_end   (bit_end)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RES_LOW;
      cnt   <= RES_LOW_LAST;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      RES_LOW: begin
        if (cnt == '0) begin
          state_d = RES_WAIT;
          cnt_d   = RES_WAIT_LAST;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RES_WAIT: begin
        if (cnt == '0) state_d = IDLE;
        else           cnt_d   = cnt - 1'b1;
      end
      IDLE: begin
        if (reset_take) begin
          state_d = RES_LOW;
          cnt_d   = RES_LOW_LAST;
        end else if (accept) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = GAP;
          cnt_d   = GAP_LAST;
        end
      end
      GAP: begin
        if (reset_take) begin
          state_d = RES_LOW;
          cnt_d   = RES_LOW_LAST;
        end else if (accept) begin
          state_d = SHIFT;
        end else if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = RES_LOW;
        cnt_d   = RES_LOW_LAST;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oled_clk   <= SCLK_IDLE;
      oled_mosi  <= 1'b0;
      oled_dc    <= 1'b0;
      oled_res_n <= 1'b0;
      oled_cs_n  <= 1'b1;
      init_done  <= 1'b0;
      busy       <= 1'b1;
      shreg      <= '0;
      bits_left  <= '0;
    end else begin
      oled_res_n <= (state_d != RES_LOW);
      oled_cs_n  <= !((state_d == SHIFT) || (state_d == GAP));
      init_done  <= (state_d == IDLE) || (state_d == SHIFT) || (state_d == GAP);
      busy       <= (state_d != IDLE);
      if (accept) begin
        shreg     <= load_word;
        oled_mosi <= load_word[DATA_W-1];
        oled_dc   <= in_dc;
        oled_clk  <= SCLK_IDLE;
        bits_left <= in_len8 ? BW'(CMD_W - 1) : BW'(DATA_W - 1);
      end else if (state == SHIFT) begin
        // Data only moves on the falling edge, so it is stable for the whole low phase.
        if (fall_tick) begin
          oled_clk  <= ~SCLK_IDLE;
          oled_mosi <= shreg[DATA_W-1];
        end
        if (rise_tick) oled_clk <= SCLK_IDLE;
        if (bit_end && !last_bit) begin
          shreg     <= shreg << 1;
          bits_left <= bits_left - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_streamer.sv
// Self-checking bench: bits sampled on each rising oled_clk are scored against
// the words pushed at handshake; timing of reset, CS and shift is counted in cycles.
module tb_oled_spi_streamer;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 16;
  localparam int RL      = 4;
  localparam int RW      = 8;
  localparam int CSI     = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_dc = 1'b0;
  logic              in_len8 = 1'b0;
  logic              hw_reset_req = 1'b0;
  logic in_ready, init_done, busy, oled_clk, oled_mosi, oled_dc, oled_res_n, oled_cs_n;

  int checks = 0;
  int errors = 0;

  logic exp_bits[$], exp_dc[$], got_bits[$], got_dc[$];
  int   low_changes = 0;
  logic prev_clk = 1'b1, prev_mosi = 1'b0;

  always #5 clock = ~clock;

  oled_spi_streamer #(
    .CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .RES_LOW_CYCLES(RL),
    .RES_WAIT_CYCLES(RW), .CS_IDLE_CYCLES(CSI)
  ) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dc(in_dc), .in_len8(in_len8), .hw_reset_req(hw_reset_req),
    .init_done(init_done), .busy(busy), .oled_clk(oled_clk), .oled_mosi(oled_mosi),
    .oled_dc(oled_dc), .oled_res_n(oled_res_n), .oled_cs_n(oled_cs_n)
  );

  // Panel-side monitor: collect the bit seen at each rising oled_clk with CS low.
  always @(negedge clock) begin
    if (oled_clk === 1'b1 && prev_clk === 1'b0 && oled_cs_n === 1'b0) begin
      got_bits.push_back(oled_mosi);
      got_dc.push_back(oled_dc);
    end
    if (oled_clk === 1'b0 && prev_clk === 1'b0 && oled_mosi !== prev_mosi) low_changes++;
    prev_clk  = oled_clk;
    prev_mosi = oled_mosi;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic dc, input logic len8);
    int n, t;
    n = len8 ? 8 : DATA_W;
    in_data = d; in_dc = dc; in_len8 = len8; in_valid = 1'b1;
    #1;
    t = 0;
    while (in_ready !== 1'b1 && t < 200) begin tick(); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL handshake_ready in_ready=%b required 1", in_ready); errors++;
    end
    for (int i = n - 1; i >= 0; i--) begin
      exp_bits.push_back(d[i]);
      exp_dc.push_back(dc);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain_scoreboard(input string tag);
    logic eb, ed, gb, gd;
    checks++;
    if (got_bits.size() != exp_bits.size()) begin
      $display("FAIL %s_edges count=%0d required %0d", tag, got_bits.size(), exp_bits.size());
      errors++;
    end
    for (int i = 0; exp_bits.size() > 0; i++) begin
      eb = exp_bits.pop_front();
      ed = exp_dc.pop_front();
      gb = (got_bits.size() > 0) ? got_bits.pop_front() : 1'bx;
      gd = (got_dc.size() > 0) ? got_dc.pop_front() : 1'bx;
      checks++;
      if (gb !== eb || gd !== ed) begin
        $display("FAIL %s_bit%0d mosi=%b dc=%b required mosi=%b dc=%b", tag, i, gb, gd, eb, ed);
        errors++;
      end
    end
    got_bits.delete();
    got_dc.delete();
  endtask

  // Counts from the current cycle: reset-low cycles, then wait cycles until init_done.
  task automatic check_init_sequence(input string tag);
    int lo, wt, t;
    logic cs_bad;
    lo = 0; wt = 0; t = 0; cs_bad = 1'b0;
    while (oled_res_n === 1'b0 && t < 100) begin
      lo++; t++;
      if (oled_cs_n !== 1'b1) cs_bad = 1'b1;
      tick();
    end
    while (oled_res_n === 1'b1 && init_done !== 1'b1 && t < 100) begin
      wt++; t++;
      if (oled_cs_n !== 1'b1 || in_ready !== 1'b0) cs_bad = 1'b1;
      tick();
    end
    checks++;
    if (lo != RL) begin $display("FAIL %s_res_low cycles=%0d required %0d", tag, lo, RL); errors++; end
    checks++;
    if (wt != RW) begin $display("FAIL %s_res_wait cycles=%0d required %0d", tag, wt, RW); errors++; end
    checks++;
    if (init_done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || oled_res_n !== 1'b1) begin
      $display("FAIL %s_ready init=%b rdy=%b busy=%b res_n=%b required 1 1 0 1",
               tag, init_done, in_ready, busy, oled_res_n);
      errors++;
    end
    checks++;
    if (cs_bad !== 1'b0) begin $display("FAIL %s_cs_during_reset bad=%b required 0", tag, cs_bad); errors++; end
  endtask

  task automatic check_word_timing(input string tag, input logic dc, input int want_low,
                                   input int want_shift);
    int lo, sh, t;
    logic dc_bad;
    lo = 0; sh = 0; t = 0; dc_bad = 1'b0;
    while (oled_cs_n === 1'b0 && t < 500) begin
      lo++; t++;
      if (in_ready === 1'b0) sh++;
      if (oled_dc !== dc) dc_bad = 1'b1;
      tick();
    end
    checks++;
    if (lo != want_low) begin $display("FAIL %s_cs_low cycles=%0d required %0d", tag, lo, want_low); errors++; end
    checks++;
    if (sh != want_shift) begin $display("FAIL %s_shift cycles=%0d required %0d", tag, sh, want_shift); errors++; end
    checks++;
    if (dc_bad !== 1'b0 || busy !== 1'b0 || oled_clk !== 1'b1) begin
      $display("FAIL %s_after dc_bad=%b busy=%b clk=%b required 0 0 1", tag, dc_bad, busy, oled_clk);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if (oled_res_n !== 0 || oled_cs_n !== 1 || oled_clk !== 1 || oled_mosi !== 0 || oled_dc !== 0 ||
        busy !== 1 || init_done !== 0 || in_ready !== 0) begin
      $display("FAIL reset_state res_n=%b cs_n=%b clk=%b mosi=%b dc=%b busy=%b init=%b rdy=%b required 0 1 1 0 0 1 0 0",
               oled_res_n, oled_cs_n, oled_clk, oled_mosi, oled_dc, busy, init_done, in_ready);
      errors++;
    end
    reset_n = 1'b1;
    check_init_sequence("powerup");
  endtask

  task automatic test_command();
    send_word(16'h00AF, 1'b0, 1'b1);
    check_word_timing("cmd", 1'b0, 2 * CLK_DIV * 8 + CSI, 2 * CLK_DIV * 8);
    drain_scoreboard("cmd");
  endtask

  task automatic test_pixel();
    send_word(16'hF800, 1'b1, 1'b0);
    check_word_timing("pix", 1'b1, 2 * CLK_DIV * 16 + CSI, 2 * CLK_DIV * 16);
    drain_scoreboard("pix");
    checks++;
    if (low_changes != 0) begin $display("FAIL pix_mosi_stable changes=%0d required 0", low_changes); errors++; end
  endtask

  task automatic test_back_to_back();
    int sh1, t;
    logic cs_bad;
    sh1 = 0; t = 0; cs_bad = 1'b0;
    send_word(16'h002C, 1'b0, 1'b1);
    while (in_ready !== 1'b1 && t < 200) begin
      sh1++; t++;
      if (oled_cs_n !== 1'b0) cs_bad = 1'b1;
      tick();
    end
    checks++;
    if (sh1 != 2 * CLK_DIV * 8 || oled_cs_n !== 1'b0) begin
      $display("FAIL b2b_first_shift cycles=%0d cs_n=%b required %0d 0", sh1, oled_cs_n, 2 * CLK_DIV * 8);
      errors++;
    end
    send_word(16'h07E0, 1'b1, 1'b0);
    checks++;
    if (oled_cs_n !== 1'b0 || oled_dc !== 1'b1 || cs_bad !== 1'b0) begin
      $display("FAIL b2b_handover cs_n=%b dc=%b cs_bad=%b required 0 1 0", oled_cs_n, oled_dc, cs_bad);
      errors++;
    end
    check_word_timing("b2b", 1'b1, 2 * CLK_DIV * 16 + CSI, 2 * CLK_DIV * 16);
    drain_scoreboard("b2b");
    checks++;
    if (low_changes != 0) begin $display("FAIL b2b_mosi_stable changes=%0d required 0", low_changes); errors++; end
  endtask

  task automatic test_midword_reset();
    int t;
    t = 0;
    send_word(16'hA5C3, 1'b1, 1'b0);
    while (got_bits.size() < 5 && t < 200) begin tick(); t++; end
    checks++;
    if (got_bits.size() != 5) begin $display("FAIL mid_progress bits=%0d required 5", got_bits.size()); errors++; end
    reset_n = 1'b0;
    #1;
    checks++;
    if (oled_cs_n !== 1 || oled_res_n !== 0 || oled_clk !== 1 || oled_mosi !== 0 || busy !== 1 ||
        init_done !== 0 || in_ready !== 0) begin
      $display("FAIL mid_reset_state cs_n=%b res_n=%b clk=%b mosi=%b busy=%b init=%b rdy=%b required 1 0 1 0 1 0 0",
               oled_cs_n, oled_res_n, oled_clk, oled_mosi, busy, init_done, in_ready);
      errors++;
    end
    exp_bits.delete(); exp_dc.delete(); got_bits.delete(); got_dc.delete();
    tick();
    reset_n = 1'b1;
    check_init_sequence("mid");
  endtask

  task automatic test_hw_reset();
    tick();
    hw_reset_req = 1'b1;
    in_valid = 1'b1; in_data = 16'h0055; in_dc = 1'b1; in_len8 = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin $display("FAIL hw_ready in_ready=%b required 0", in_ready); errors++; end
    tick();
    hw_reset_req = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (init_done !== 0 || oled_cs_n !== 1 || oled_res_n !== 0 || busy !== 1) begin
      $display("FAIL hw_next init=%b cs_n=%b res_n=%b busy=%b required 0 1 0 1",
               init_done, oled_cs_n, oled_res_n, busy);
      errors++;
    end
    check_init_sequence("hw");
    checks++;
    if (got_bits.size() != 0) begin $display("FAIL hw_no_word bits=%0d required 0", got_bits.size()); errors++; end
    send_word(16'h0081, 1'b0, 1'b1);
    check_word_timing("hw_cmd", 1'b0, 2 * CLK_DIV * 8 + CSI, 2 * CLK_DIV * 8);
    drain_scoreboard("hw_cmd");
  endtask

  initial begin
    test_reset();
    test_command();
    test_pixel();
    test_back_to_back();
    test_midword_reset();
    test_hw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
